fg_sweep_ctrl: RTL and testbench
================================

# fg_sweep_ctrl

Frequency-sweep sequencer for the function generator's timer. Drives the timer's enable and per-tick increment (the overflow-mode `counter_i`) so the output frequency steps from a start increment to a stop increment. Dwell time per step is counted in timer `clk_en_o` ticks. Sits between the register/config interface and the timer; the timer itself is unchanged.

## Interface
**Parameters**
- `COUNTER_BITWIDTH`, 10, width of increment values; matches the timer counter width.
- `DWELL_BITWIDTH`, 8, width of the dwell counter.

**Ports** (name, direction, width, meaning)
- `clk_i` input 1: the single clock.
- `rstn_i` input 1: reset; **synchronous, active-low**.
- `start_i` input 1: start request, pulse; accepted only when not busy.
- `abort_i` input 1: stop the sweep and disable the timer; highest priority.
- `mode_i` input 2: sweep mode; 00 one-shot, 01 sawtooth repeat, 10 triangle, 11 treated as 00.
- `startInc_i` input COUNTER_BITWIDTH: first increment.
- `stopInc_i` input COUNTER_BITWIDTH: final increment.
- `stepInc_i` input COUNTER_BITWIDTH: magnitude of change per step.
- `dwell_i` input DWELL_BITWIDTH: ticks per step minus one.
- `tick_i` input 1: timer `clk_en_o`.
- `increment_o` output COUNTER_BITWIDTH: to timer `counter_i`.
- `timerEnable_o` output 1: to timer `enable_i`; the timer is run in overflow mode.
- `busy_o` output 1: high in PRIME and RUN.
- `stepStrobe_o` output 1: one-cycle pulse when `increment_o` changes during RUN.
- `done_o` output 1: one-cycle pulse on one-shot completion.

## Operation
**Start**
- On acceptance, `mode_i`, `startInc_i`, `stopInc_i`, `stepInc_i` and `dwell_i` are latched. Later input changes have no effect until the next start.
- Direction is up if stop ≥ start, otherwise down.

**States**
- IDLE: `timerEnable_o` = 0. Accepted start → PRIME.
- PRIME: exactly 1 cycle. `timerEnable_o` = 0, so the timer reloads its preload. `increment_o` ← startInc, dwell counter ← 0. → RUN.
- RUN: `timerEnable_o` = 1. Each `tick_i` increments the dwell counter.
- Step boundary: when `tick_i` arrives with the dwell counter == dwell, the counter is cleared and the step advances.
  - Not at the end value: next = cur ± step, computed in COUNTER_BITWIDTH+1 bits. If the result passes stop (or wraps), it is clamped to stop.
  - At stop, one-shot: → HOLD, `done_o` pulses.
  - At stop, sawtooth: `increment_o` ← startInc.
  - At stop, triangle: direction reverses and the sweep runs back toward start. At start it reverses again. The turning value is not repeated; the next value is the end value ∓ step, clamped.
- HOLD: `timerEnable_o` = 1, `increment_o` = stop, `busy_o` = 0. Accepted start → PRIME.

**Boundary cases**
- step == 0, or start == stop: the end is reached at the first boundary.
  - One-shot: one dwell, then HOLD.
  - Repeat and triangle: `increment_o` is held constant; `stepStrobe_o` still pulses each boundary.
- abort_i in any state → IDLE on the next cycle. `timerEnable_o` drops; `increment_o` holds its value. If abort and start occur in the same cycle, abort wins.
- start_i while `busy_o` = 1: ignored.
- tick_i outside RUN: ignored.

## Timing
- Reset: state IDLE; `increment_o`, dwell counter and direction = 0; all 1-bit outputs 0.
- Start accepted at cycle t (IDLE/HOLD): PRIME at t+1, RUN with `timerEnable_o` = 1 from t+2.
- `increment_o` = startInc from t+2.
- Step boundary on a tick at cycle c:
  - `increment_o` takes the new value at c+1; `stepStrobe_o` is high during c+1.
  - The timer consumes the new increment from its next tick onward.
- Step length: exactly dwell+1 ticks.
- `done_o` is high during the first HOLD cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `fg_pkg` holds:
  - state encoding `fg_sweep_state_t` (IDLE, PRIME, RUN, HOLD);
  - mode constants `FG_SWEEP_ONESHOT`, `FG_SWEEP_SAW`, `FG_SWEEP_TRI`.
- Sub-module `fg_sweep_step`: combinational next-increment computation. Inputs are cur, step, stop/start limit and direction. Outputs are next value, at_end flag and clamp flag. It contains the wide add/sub and clamp logic.
- Top level: FSM, config latch, dwell counter and output registers.

## Test plan
- Reset mid-RUN (rstn_i low for 1 cycle) → next cycle IDLE, all outputs 0. A later start works normally.
- One-shot up sweep: start=10, stop=40, step=10, dwell=2, tick every 4th cycle.
  - Required: `increment_o` 10,20,30,40, each held 3 ticks; `done_o` one pulse; HOLD with enable=1.
  - Required: 3 `stepStrobe_o` pulses before HOLD.
- Clamp and down sweep: start=50, stop=5, step=20, dwell=0.
  - Required: 50,30,10,5, then HOLD. No wrap below 5.
- Triangle: start=2, stop=6, step=2, dwell=0, tick every cycle.
  - Required: 2,4,6,4,2,4,6… with no repeated turning values; `done_o` never pulses.
- Abort/start interaction:
  - start while busy → ignored;
  - abort+start in the same cycle during RUN → IDLE, enable=0, `increment_o` frozen;
  - step=0 sawtooth → constant increment, strobe every dwell+1 ticks.

Source files
------------

// File: rtl/fg_pkg.sv
// rtl/fg_pkg.sv - shared types and constants for the function generator sweep logic
package fg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    RUN   = 2'b10,
    HOLD  = 2'b11
  } fg_sweep_state_t;

  localparam logic [1:0] FG_SWEEP_ONESHOT = 2'b00;
  localparam logic [1:0] FG_SWEEP_SAW     = 2'b01;
  localparam logic [1:0] FG_SWEEP_TRI     = 2'b10;

  // Mode 11 has no meaning of its own and behaves as one-shot.
  function automatic logic [1:0] fg_norm_mode(input logic [1:0] mode);
    return (mode == 2'b11) ? FG_SWEEP_ONESHOT : mode;
  endfunction

endpackage

// File: rtl/fg_sweep_step.sv
// rtl/fg_sweep_step.sv - next-increment computation with end detection and clamping
module fg_sweep_step #(
  parameter int COUNTER_BITWIDTH = 10
) (
  input  logic [COUNTER_BITWIDTH-1:0] cur,
  input  logic [COUNTER_BITWIDTH-1:0] step,
  input  logic [COUNTER_BITWIDTH-1:0] limit,
  input  logic                        dir_up,
  output logic [COUNTER_BITWIDTH-1:0] next_val,
  output logic                        at_end,
  output logic                        clamp
);

  localparam int W = COUNTER_BITWIDTH;

  logic [W:0] wide;

  // One extra bit catches both overflow past the top and borrow below zero.
  always_comb begin
    wide     = '0;
    clamp    = 1'b0;
    next_val = '0;
    if (dir_up) begin
      wide  = {1'b0, cur} + {1'b0, step};
      clamp = (wide > {1'b0, limit});
    end else begin
      wide  = {1'b0, cur} - {1'b0, step};
      clamp = wide[W] || (wide[W-1:0] < limit);
    end
    next_val = clamp ? limit : wide[W-1:0];
    // A zero step can never make progress, so it counts as already at the end.
    at_end   = (cur == limit) || (step == '0);
  end

endmodule

// File: rtl/fg_sweep_ctrl.sv
// rtl/fg_sweep_ctrl.sv - frequency-sweep sequencer driving the timer increment and enable
module fg_sweep_ctrl
  import fg_pkg::*;
#(
  parameter int COUNTER_BITWIDTH = 10,
  parameter int DWELL_BITWIDTH   = 8
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [1:0]                  mode_i,
  input  logic [COUNTER_BITWIDTH-1:0] startInc_i,
  input  logic [COUNTER_BITWIDTH-1:0] stopInc_i,
  input  logic [COUNTER_BITWIDTH-1:0] stepInc_i,
  input  logic [DWELL_BITWIDTH-1:0]   dwell_i,
  input  logic                        tick_i,
  output logic [COUNTER_BITWIDTH-1:0] increment_o,
  output logic                        timerEnable_o,
  output logic                        busy_o,
  output logic                        stepStrobe_o,
  output logic                        done_o
);

  localparam int CW = COUNTER_BITWIDTH;
  localparam int DW = DWELL_BITWIDTH;

  fg_sweep_state_t state;

  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_start;
  logic [CW-1:0] cfg_stop;
  logic [CW-1:0] cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic          base_up;
  logic          dir_up;
  logic [DW-1:0] dwell_cnt;

  // Heading toward stop when the live direction matches the configured one.
  logic          toward_stop;
  logic [CW-1:0] fwd_limit;
  logic [CW-1:0] rev_limit;
  logic [CW-1:0] fwd_next;
  logic [CW-1:0] rev_next;
  logic          fwd_at_end;
  logic          rev_at_end;
  logic          fwd_clamp;
  logic          rev_clamp;

  assign toward_stop = (dir_up == base_up);
  assign fwd_limit   = toward_stop ? cfg_stop  : cfg_start;
  assign rev_limit   = toward_stop ? cfg_start : cfg_stop;

  // Continue in the current direction.
  fg_sweep_step #(.COUNTER_BITWIDTH(CW)) u_step_fwd (
    .cur      (increment_o),
    .step     (cfg_step),
    .limit    (fwd_limit),
    .dir_up   (dir_up),
    .next_val (fwd_next),
    .at_end   (fwd_at_end),
    .clamp    (fwd_clamp)
  );

  // Triangle turnaround: first value after reversing, so the end value is not repeated.
  fg_sweep_step #(.COUNTER_BITWIDTH(CW)) u_step_rev (
    .cur      (increment_o),
    .step     (cfg_step),
    .limit    (rev_limit),
    .dir_up   (~dir_up),
    .next_val (rev_next),
    .at_end   (rev_at_end),
    .clamp    (rev_clamp)
  );

  // Sweep FSM with config latch, dwell counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      cfg_mode      <= FG_SWEEP_ONESHOT;
      cfg_start     <= '0;
      cfg_stop      <= '0;
      cfg_step      <= '0;
      cfg_dwell     <= '0;
      base_up       <= 1'b0;
      dir_up        <= 1'b0;
      dwell_cnt     <= '0;
      increment_o   <= '0;
      timerEnable_o <= 1'b0;
      busy_o        <= 1'b0;
      stepStrobe_o  <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      stepStrobe_o <= 1'b0;
      done_o       <= 1'b0;
      if (abort_i) begin
        state         <= IDLE;
        timerEnable_o <= 1'b0;
        busy_o        <= 1'b0;
      end else begin
        case (state)
          IDLE, HOLD: begin
            if (start_i) begin
              cfg_mode      <= fg_norm_mode(mode_i);
              cfg_start     <= startInc_i;
              cfg_stop      <= stopInc_i;
              cfg_step      <= stepInc_i;
              cfg_dwell     <= dwell_i;
              base_up       <= (stopInc_i >= startInc_i);
              timerEnable_o <= 1'b0;
              busy_o        <= 1'b1;
              state         <= PRIME;
            end
          end
          PRIME: begin
            // Enable stays low for this cycle so the timer reloads its preload.
            increment_o   <= cfg_start;
            dwell_cnt     <= '0;
            dir_up        <= base_up;
            timerEnable_o <= 1'b1;
            state         <= RUN;
          end
          RUN: begin
            if (tick_i) begin
              if (dwell_cnt == cfg_dwell) begin
                dwell_cnt <= '0;
                if (!fwd_at_end) begin
                  increment_o  <= fwd_clamp ? fwd_limit : fwd_next;
                  stepStrobe_o <= 1'b1;
                end else begin
                  case (cfg_mode)
                    FG_SWEEP_SAW: begin
                      increment_o  <= cfg_start;
                      stepStrobe_o <= 1'b1;
                    end
                    FG_SWEEP_TRI: begin
                      dir_up       <= ~dir_up;
                      stepStrobe_o <= 1'b1;
                      if (rev_at_end) begin
                        increment_o <= increment_o;
                      end else if (rev_clamp) begin
                        increment_o <= rev_limit;
                      end else begin
                        increment_o <= rev_next;
                      end
                    end
                    default: begin
                      increment_o <= cfg_stop;
                      busy_o      <= 1'b0;
                      done_o      <= 1'b1;
                      state       <= HOLD;
                    end
                  endcase
                end
              end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fg_sweep_ctrl.sv
// tb/tb_fg_sweep_ctrl.sv - directed self-checking bench for fg_sweep_ctrl
module tb_fg_sweep_ctrl;

  localparam int CW = 10;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          start_i;
  logic          abort_i;
  logic [1:0]    mode_i;
  logic [CW-1:0] startInc_i;
  logic [CW-1:0] stopInc_i;
  logic [CW-1:0] stepInc_i;
  logic [DW-1:0] dwell_i;
  logic          tick_i;
  logic [CW-1:0] increment_o;
  logic          timerEnable_o;
  logic          busy_o;
  logic          stepStrobe_o;
  logic          done_o;

  int checks   = 0;
  int failures = 0;

  int seq[$];
  int hold[$];
  int strobes = 0;
  int dones   = 0;
  logic prev_run = 1'b0;

  always #5 clk_i = ~clk_i;

  fg_sweep_ctrl #(.COUNTER_BITWIDTH(CW), .DWELL_BITWIDTH(DW)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .mode_i        (mode_i),
    .startInc_i    (startInc_i),
    .stopInc_i     (stopInc_i),
    .stepInc_i     (stepInc_i),
    .dwell_i       (dwell_i),
    .tick_i        (tick_i),
    .increment_o   (increment_o),
    .timerEnable_o (timerEnable_o),
    .busy_o        (busy_o),
    .stepStrobe_o  (stepStrobe_o),
    .done_o        (done_o)
  );

  // Log each value seen in RUN and how many ticks it was held for.
  always @(negedge clk_i) begin
    logic run;
    run = busy_o && timerEnable_o;
    if (run && (!prev_run || stepStrobe_o)) begin
      seq.push_back(int'(increment_o));
      hold.push_back(0);
    end
    if (run && tick_i) hold[hold.size()-1] = hold[hold.size()-1] + 1;
    if (stepStrobe_o) strobes = strobes + 1;
    if (done_o) dones = dones + 1;
    prev_run = run;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_sweep(input logic [1:0] m, input logic [CW-1:0] s, input logic [CW-1:0] e,
                             input logic [CW-1:0] st, input logic [DW-1:0] dw);
    mode_i     = m;
    startInc_i = s;
    stopInc_i  = e;
    stepInc_i  = st;
    dwell_i    = dw;
    start_i    = 1'b1;
    cyc();
    start_i    = 1'b0;
  endtask

  initial begin
    int i0;
    int s0;
    int d0;
    int got;
    logic [CW-1:0] frozen;
    int exp_a[4];
    int exp_b[4];
    int exp_c[7];

    exp_a = '{10, 20, 30, 40};
    exp_b = '{50, 30, 10, 5};
    exp_c = '{2, 4, 6, 4, 2, 4, 6};

    rstn_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; tick_i = 1'b0;
    mode_i = 2'b00; startInc_i = '0; stopInc_i = '0; stepInc_i = '0; dwell_i = '0;
    cyc();
    cyc();
    chk("rst_inc", increment_o, 0);
    chk("rst_en", timerEnable_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_strobe", stepStrobe_o, 0);
    chk("rst_done", done_o, 0);
    rstn_i = 1'b1;

    // Reset pulse in the middle of RUN.
    tick_i = 1'b1;
    start_sweep(2'b00, 10'd100, 10'd200, 10'd1, 8'd3);
    cyc();
    cyc();
    cyc();
    chk("mid_run_busy", busy_o, 1);
    rstn_i = 1'b0;
    cyc();
    rstn_i = 1'b1;
    chk("mrst_inc", increment_o, 0);
    chk("mrst_en", timerEnable_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_strobe", stepStrobe_o, 0);
    tick_i = 1'b0;
    cyc();

    // One-shot up sweep, tick every 4th cycle, a start request while busy, inputs changed mid-run.
    i0 = seq.size(); s0 = strobes; d0 = dones;
    start_sweep(2'b00, 10'd10, 10'd40, 10'd10, 8'd2);
    chk("A_prime_busy", busy_o, 1);
    chk("A_prime_en", timerEnable_o, 0);
    cyc();
    chk("A_run_en", timerEnable_o, 1);
    chk("A_run_inc", increment_o, 10);
    got = 0;
    for (int k = 0; k < 200; k++) begin
      tick_i  = (k % 4 == 0);
      start_i = (k == 5);
      if (k == 5) begin
        startInc_i = 10'd99;
        stopInc_i  = 10'd300;
      end
      cyc();
      if (done_o) begin
        got = 1;
        break;
      end
    end
    start_i = 1'b0;
    tick_i  = 1'b0;
    chk("A_done_seen", got, 1);
    chk("A_hold_busy", busy_o, 0);
    chk("A_hold_en", timerEnable_o, 1);
    chk("A_hold_inc", increment_o, 40);
    cyc();
    chk("A_done_one_cycle", done_o, 0);
    chk("A_nvals", seq.size() - i0, 4);
    for (int i = 0; i < 4; i++) begin
      if (i0 + i < seq.size()) begin
        chk($sformatf("A_val%0d", i), seq[i0+i], exp_a[i]);
        chk($sformatf("A_ticks%0d", i), hold[i0+i], 3);
      end
    end
    chk("A_strobes", strobes - s0, 3);
    chk("A_dones", dones - d0, 1);

    // Down sweep with clamp at the stop value, started from HOLD.
    i0 = seq.size(); d0 = dones;
    start_sweep(2'b11, 10'd50, 10'd5, 10'd20, 8'd0);
    chk("B_prime_en", timerEnable_o, 0);
    tick_i = 1'b1;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (done_o) begin
        got = 1;
        break;
      end
    end
    tick_i = 1'b0;
    chk("B_done_seen", got, 1);
    chk("B_hold_inc", increment_o, 5);
    chk("B_nvals", seq.size() - i0, 4);
    for (int i = 0; i < 4; i++) begin
      if (i0 + i < seq.size()) chk($sformatf("B_val%0d", i), seq[i0+i], exp_b[i]);
    end

    // Triangle, tick every cycle, then abort together with start.
    cyc();
    i0 = seq.size(); d0 = dones;
    start_sweep(2'b10, 10'd2, 10'd6, 10'd2, 8'd0);
    tick_i = 1'b1;
    for (int k = 0; k < 12; k++) cyc();
    chk("C_nvals_ge7", (seq.size() - i0) >= 7, 1);
    for (int i = 0; i < 7; i++) begin
      if (i0 + i < seq.size()) chk($sformatf("C_val%0d", i), seq[i0+i], exp_c[i]);
    end
    chk("C_no_done", dones - d0, 0);
    chk("C_busy", busy_o, 1);
    frozen  = increment_o;
    abort_i = 1'b1;
    start_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    start_i = 1'b0;
    tick_i  = 1'b0;
    chk("C_abort_busy", busy_o, 0);
    chk("C_abort_en", timerEnable_o, 0);
    chk("C_abort_inc", increment_o, frozen);
    cyc();
    chk("C_abort_stay_idle", busy_o, 0);
    chk("C_abort_inc_hold", increment_o, frozen);

    // Sawtooth with zero step: constant value, strobe every dwell+1 ticks.
    i0 = seq.size(); s0 = strobes;
    start_sweep(2'b01, 10'd7, 10'd20, 10'd0, 8'd1);
    tick_i = 1'b1;
    for (int k = 0; k < 12; k++) cyc();
    chk("D_strobes", strobes - s0, 5);
    chk("D_nvals", seq.size() - i0, 6);
    for (int i = 0; i < 4; i++) begin
      if (i0 + i < seq.size()) chk($sformatf("D_val%0d", i), seq[i0+i], 7);
    end
    for (int i = 0; i < 3; i++) begin
      if (i0 + i < hold.size()) chk($sformatf("D_ticks%0d", i), hold[i0+i], 2);
    end
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    tick_i  = 1'b0;
    chk("D_abort_en", timerEnable_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
